// File: rtl/lsu_riscv.sv
// Load/store unit: turns an effective address into one word-addressed memory
// access with lane steering, byte enables, load extension and a stall/timeout FSM.
module lsu_riscv #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misalign_o,
    output logic        fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       size_q;
    logic [1:0]       off_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;

    logic        illegal;
    logic        accept;
    logic        complete;
    logic        timed_out;
    logic [3:0]  be_next;
    logic [31:0] wd_next;
    logic [31:0] rd_shifted;
    logic [31:0] rd_ext;

    // Size/offset legality; codes 3, 6 and 7 are not loads or stores at all.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        illegal = 1'b0;
        case (core_size_i)
            F3_B, F3_BU: illegal = 1'b0;
            F3_H, F3_HU: illegal = core_addr_i[0];
            F3_W:        illegal = |core_addr_i[1:0];
            default:     illegal = 1'b1;
        endcase
    end

    assign misalign_o = core_req_i & (state_q == ST_IDLE) & illegal;
    assign accept     = core_req_i & (state_q == ST_IDLE) & ~illegal;
    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign complete   = (state_q == ST_BUSY) & mem_ready_i;
    assign timed_out  = (state_q == ST_BUSY) & ~mem_ready_i & TIMEOUT_EN & (cnt_inc == TIMEOUT_VAL);

    // Store lanes are replicated so the memory only has to honour mem_be_o.
    always_comb begin
        be_next = 4'b1111;
        wd_next = core_wd_i;
        case (core_size_i[1:0])
            2'b00: begin
                be_next = 4'b0001 << core_addr_i[1:0];
                wd_next = {4{core_wd_i[7:0]}};
            end
            2'b01: begin
                be_next = 4'b0011 << core_addr_i[1:0];
                wd_next = {2{core_wd_i[15:0]}};
            end
            default: begin
                be_next = 4'b1111;
                wd_next = core_wd_i;
            end
        endcase
    end

    assign rd_shifted = mem_rd_i >> {off_q, 3'b000};

    always_comb begin
        rd_ext = mem_rd_i;
        case (size_q)
            F3_B:    rd_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            F3_BU:   rd_ext = {24'h0, rd_shifted[7:0]};
            F3_H:    rd_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            F3_HU:   rd_ext = {16'h0, rd_shifted[15:0]};
            default: rd_ext = mem_rd_i;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        core_stall_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                core_stall_o = accept;
                if (accept) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                core_stall_o = 1'b1;
                if (complete || timed_out) state_d = ST_RESP;
            end
            ST_RESP: begin
                core_stall_o = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_be_o   <= 4'b0;
            mem_addr_o <= 32'h0;
            mem_wd_o   <= 32'h0;
            size_q     <= 3'd0;
            off_q      <= 2'd0;
            cnt_q      <= '0;
        end else if (accept) begin
            mem_req_o  <= 1'b1;
            mem_we_o   <= core_we_i;
            mem_be_o   <= be_next;
            mem_addr_o <= {core_addr_i[31:2], 2'b00};
            mem_wd_o   <= wd_next;
            size_q     <= core_size_i;
            off_q      <= core_addr_i[1:0];
            cnt_q      <= '0;
        end else if (complete || timed_out) begin
            mem_req_o <= 1'b0;
        end else if (state_q == ST_BUSY) begin
            cnt_q <= cnt_inc;
        end
    end

    // Response registers hold until the next completion so the core can read them late.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            core_rd_o <= 32'h0;
            fault_o   <= 1'b0;
        end else if (complete) begin
            core_rd_o <= mem_we_o ? 32'h0 : rd_ext;
            fault_o   <= 1'b0;
        end else if (timed_out) begin
            core_rd_o <= 32'h0;
            fault_o   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lsu_riscv.sv
// Directed bench for lsu_riscv: lane steering, extension, stall latency,
// misalignment, timeout and asynchronous reset, with hand-computed expectations.
module tb_lsu_riscv;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        misalign_o;
    logic        fault_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_riscv #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .misalign_o   (misalign_o),
        .fault_o      (fault_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One access from IDLE through RESP; ready is raised in BUSY cycle waits+1.
    task automatic access(input string tag, input logic we, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int waits,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_rd);
        int stalls;
        stalls      = 0;
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_rd_i    = rd;
        mem_ready_i = 1'b0;
        #1;
        check({tag, " misalign"}, 32'(misalign_o), 32'd0);
        if (core_stall_o) stalls++;
        tick();
        for (int i = 0; i <= waits; i++) begin
            check({tag, " mem_req"},  32'(mem_req_o), 32'd1);
            check({tag, " mem_we"},   32'(mem_we_o), 32'(we));
            check({tag, " mem_be"},   32'(mem_be_o), 32'(exp_be));
            check({tag, " mem_addr"}, mem_addr_o, exp_addr);
            check({tag, " mem_wd"},   mem_wd_o, exp_wd);
            if (core_stall_o) stalls++;
            mem_ready_i = (i == waits);
            tick();
        end
        mem_ready_i = 1'b0;
        check({tag, " resp stall"},   32'(core_stall_o), 32'd0);
        check({tag, " resp mem_req"}, 32'(mem_req_o), 32'd0);
        check({tag, " core_rd"},      core_rd_o, exp_rd);
        check({tag, " fault"},        32'(fault_o), 32'd0);
        check({tag, " stall cycles"}, 32'(stalls), 32'(waits + 2));
        core_req_i = 1'b0;
        tick();
        check({tag, " idle stall"}, 32'(core_stall_o), 32'd0);
    endtask

    task automatic illegal(input string tag, input logic we, input logic [2:0] size,
                           input logic [31:0] addr);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = 32'h1234_5678;
        #1;
        check({tag, " misalign"}, 32'(misalign_o), 32'd1);
        check({tag, " stall"},    32'(core_stall_o), 32'd0);
        tick();
        check({tag, " mem_req after edge"}, 32'(mem_req_o), 32'd0);
        check({tag, " misalign held"},      32'(misalign_o), 32'd1);
        core_req_i = 1'b0;
        tick();
    endtask

    initial begin
        rst_ni      = 1'b0;
        core_req_i  = 1'b0;
        core_we_i   = 1'b0;
        core_size_i = 3'd0;
        core_addr_i = 32'h0;
        core_wd_i   = 32'h0;
        mem_rd_i    = 32'h0;
        mem_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset mem_req",  32'(mem_req_o), 32'd0);
        check("reset mem_be",   32'(mem_be_o), 32'd0);
        check("reset mem_addr", mem_addr_o, 32'h0);
        check("reset core_rd",  core_rd_o, 32'h0);
        check("reset fault",    32'(fault_o), 32'd0);
        check("reset stall",    32'(core_stall_o), 32'd0);
        rst_ni = 1'b1;
        tick();

        // Loads on a word whose top byte is negative.
        access("LB 1003",  1'b0, 3'd0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0,
               32'h0000_1000, 4'b1000, 32'h0000_0000, 32'hFFFF_FF80);
        access("LBU 1002", 1'b0, 3'd4, 32'h0000_1002, 32'h0, 32'h80FF_1234, 0,
               32'h0000_1000, 4'b0100, 32'h0000_0000, 32'h0000_00FF);
        access("LB 1001",  1'b0, 3'd0, 32'h0000_1001, 32'h0, 32'h80FF_1234, 1,
               32'h0000_1000, 4'b0010, 32'h0000_0000, 32'h0000_0012);
        access("LHU 2002", 1'b0, 3'd5, 32'h0000_2002, 32'h0, 32'h80FF_1234, 0,
               32'h0000_2000, 4'b1100, 32'h0000_0000, 32'h0000_80FF);
        access("LH 2002",  1'b0, 3'd1, 32'h0000_2002, 32'h0, 32'h80FF_1234, 0,
               32'h0000_2000, 4'b1100, 32'h0000_0000, 32'hFFFF_80FF);
        access("LW 2000",  1'b0, 3'd2, 32'h0000_2000, 32'h0, 32'h80FF_1234, 0,
               32'h0000_2000, 4'b1111, 32'h0000_0000, 32'h80FF_1234);

        // Stores: core_rd must drop to zero after the preceding non-zero load.
        access("SB 3001", 1'b1, 3'd0, 32'h0000_3001, 32'hAABB_CCDD, 32'hFFFF_FFFF, 0,
               32'h0000_3000, 4'b0010, 32'hDDDD_DDDD, 32'h0);
        access("SH 3002", 1'b1, 3'd1, 32'h0000_3002, 32'hAABB_CCDD, 32'hFFFF_FFFF, 3,
               32'h0000_3000, 4'b1100, 32'hCCDD_CCDD, 32'h0);
        access("SW 3000", 1'b1, 3'd2, 32'h0000_3000, 32'hAABB_CCDD, 32'hFFFF_FFFF, 0,
               32'h0000_3000, 4'b1111, 32'hAABB_CCDD, 32'h0);
        access("SBU 3003", 1'b1, 3'd4, 32'h0000_3003, 32'h0000_00A5, 32'hFFFF_FFFF, 0,
               32'h0000_3000, 4'b1000, 32'hA5A5_A5A5, 32'h0);

        illegal("LW 4002",  1'b0, 3'd2, 32'h0000_4002);
        illegal("SH 4001",  1'b1, 3'd1, 32'h0000_4001);
        illegal("size3",    1'b0, 3'd3, 32'h0000_4000);

        // Leave a non-zero load result so the timeout visibly clears it.
        access("LW pre-timeout", 1'b0, 3'd2, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 0,
               32'h0000_5000, 4'b1111, 32'h0000_0000, 32'hCAFE_F00D);

        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h0000_6000;
        mem_ready_i = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("timeout busy stall",   32'(core_stall_o), 32'd1);
            check("timeout busy mem_req", 32'(mem_req_o), 32'd1);
            tick();
        end
        check("timeout resp stall",   32'(core_stall_o), 32'd0);
        check("timeout resp mem_req", 32'(mem_req_o), 32'd0);
        check("timeout fault",        32'(fault_o), 32'd1);
        check("timeout core_rd",      core_rd_o, 32'h0);
        core_req_i = 1'b0;
        tick();
        check("fault held in idle", 32'(fault_o), 32'd1);

        access("LW after timeout", 1'b0, 3'd2, 32'h0000_6000, 32'h0, 32'h1357_9BDF, 0,
               32'h0000_6000, 4'b1111, 32'h0000_0000, 32'h1357_9BDF);

        // Reset in the middle of an access drops the request immediately.
        core_req_i  = 1'b1;
        core_we_i   = 1'b1;
        core_size_i = 3'd2;
        core_addr_i = 32'h0000_7004;
        core_wd_i   = 32'hDEAD_BEEF;
        tick();
        check("pre-reset mem_req", 32'(mem_req_o), 32'd1);
        core_req_i = 1'b0;
        rst_ni     = 1'b0;
        #1;
        check("async reset mem_req",  32'(mem_req_o), 32'd0);
        check("async reset mem_we",   32'(mem_we_o), 32'd0);
        check("async reset mem_addr", mem_addr_o, 32'h0);
        check("async reset mem_wd",   mem_wd_o, 32'h0);
        check("async reset core_rd",  core_rd_o, 32'h0);
        check("async reset stall",    32'(core_stall_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        check("post-reset mem_req", 32'(mem_req_o), 32'd0);
        check("post-reset mem_be",  32'(mem_be_o), 32'd0);
        check("post-reset stall",   32'(core_stall_o), 32'd0);
        check("post-reset fault",   32'(fault_o), 32'd0);

        access("LHU after reset", 1'b0, 3'd5, 32'h0000_8000, 32'h0, 32'h1234_8001, 0,
               32'h0000_8000, 4'b0011, 32'h0000_0000, 32'h0000_8001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
